sid_envelope: RTL

SID_ENVELOPE -- requirements
Module: sid_envelope

---
 rtl/sid_envelope.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sid_envelope.sv
// SID-style ADSR envelope generator for one voice, with amplitude scaling of the
// oscillator output by the current envelope level.
module sid_envelope #(
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        iRstN,
    input  logic        clkEn,
    input  logic        iWE,
    input  logic [4:0]  iAddr,
    input  logic [7:0]  iData,
    input  logic [11:0] iVoice,
    output logic [7:0]  oEnv,
    output logic [19:0] oOut
);

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned ENV_W   = 8;
    localparam int unsigned CNT_W   = 15;
    localparam int unsigned EXP_W   = 5;
    localparam int unsigned OUT_W   = 20;
    localparam int unsigned VOICE_W = 12;

    localparam logic [ADDR_W-1:0] ADDR_GATE = ADDR_W'(BASE_ADDR + 4);
    localparam logic [ADDR_W-1:0] ADDR_AD   = ADDR_W'(BASE_ADDR + 5);
    localparam logic [ADDR_W-1:0] ADDR_SR   = ADDR_W'(BASE_ADDR + 6);

    typedef enum logic [1:0] {
        ATTACK        = 2'd0,
        DECAY_SUSTAIN = 2'd1,
        RELEASE       = 2'd2
    } envState_t;

    envState_t          state;
    logic [ENV_W-1:0]   env;
    logic [CNT_W-1:0]   rateCnt;
    logic [EXP_W-1:0]   expCnt;
    logic               gate;
    logic               gatePrev;
    logic [3:0]         attackRate;
    logic [3:0]         decayRate;
    logic [3:0]         sustainLvl;
    logic [3:0]         releaseRate;

    logic [3:0]         rateIdx;
    logic [CNT_W-1:0]   period;
    logic               rateEvent;
    logic [EXP_W:0]     expNext;
    logic               expDue;
    logic               gateRise;
    logic               gateFall;
    logic               decayAllowed;
    logic [VOICE_W:0]   voiceCentered;
    logic signed [OUT_W-1:0] scaled;

    // Tick count between rate events, per rate index.
    function automatic logic [CNT_W-1:0] ratePeriod(input logic [3:0] idx);
        logic [CNT_W-1:0] p;
        p = 15'd8;
        case (idx)
            4'd0:  p = 15'd8;
            4'd1:  p = 15'd31;
            4'd2:  p = 15'd62;
            4'd3:  p = 15'd94;
            4'd4:  p = 15'd148;
            4'd5:  p = 15'd219;
            4'd6:  p = 15'd266;
            4'd7:  p = 15'd312;
            4'd8:  p = 15'd391;
            4'd9:  p = 15'd976;
            4'd10: p = 15'd1953;
            4'd11: p = 15'd3125;
            4'd12: p = 15'd3906;
            4'd13: p = 15'd11719;
            4'd14: p = 15'd19531;
            4'd15: p = 15'd31250;
            default: p = 15'd8;
        endcase
        return p;
    endfunction

    // Rate events per envelope step on the falling slopes; approximates an exponential curve.
    function automatic logic [EXP_W-1:0] expPeriod(input logic [ENV_W-1:0] lvl);
        logic [EXP_W-1:0] e;
        e = 5'd1;
        if (lvl >= 8'd94)      e = 5'd1;
        else if (lvl >= 8'd55) e = 5'd2;
        else if (lvl >= 8'd27) e = 5'd4;
        else if (lvl >= 8'd15) e = 5'd8;
        else if (lvl >= 8'd7)  e = 5'd16;
        else if (lvl >= 8'd1)  e = 5'd30;
        else                   e = 5'd1;
        return e;
    endfunction

    always_comb begin
        rateIdx = releaseRate;
        case (state)
            ATTACK:        rateIdx = attackRate;
            DECAY_SUSTAIN: rateIdx = decayRate;
            default:       rateIdx = releaseRate;
        endcase
        period        = ratePeriod(rateIdx);
        rateEvent     = (rateCnt == period);
        expNext       = {1'b0, expCnt} + (EXP_W+1)'(1);
        expDue        = (expNext >= {1'b0, expPeriod(env)});
        gateRise      = gate & ~gatePrev;
        gateFall      = ~gate & gatePrev;
        // Sustain level nibble replicated into both halves equals sustain*17.
        decayAllowed  = (state == DECAY_SUSTAIN) ? (env > {sustainLvl, sustainLvl})
                                                 : (env != '0);
        voiceCentered = {1'b0, iVoice} - (VOICE_W+1)'('h800);
        scaled        = OUT_W'($signed(voiceCentered)) * OUT_W'($signed({1'b0, env}));
    end

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            state       <= RELEASE;
            env         <= '0;
            oOut        <= '0;
            rateCnt     <= '0;
            expCnt      <= '0;
            gate        <= 1'b0;
            gatePrev    <= 1'b0;
            attackRate  <= '0;
            decayRate   <= '0;
            sustainLvl  <= '0;
            releaseRate <= '0;
        end else begin
            oOut <= scaled;

            if (iWE) begin
                if (iAddr == ADDR_GATE) begin
                    gate <= iData[0];
                end else if (iAddr == ADDR_AD) begin
                    attackRate <= iData[7:4];
                    decayRate  <= iData[3:0];
                end else if (iAddr == ADDR_SR) begin
                    sustainLvl  <= iData[7:4];
                    releaseRate <= iData[3:0];
                end
            end

            if (clkEn) begin
                gatePrev <= gate;
                rateCnt  <= rateEvent ? '0 : rateCnt + CNT_W'(1);

                // Gate edges take priority over the envelope step on the same tick.
                if (gateRise) begin
                    state  <= ATTACK;
                    expCnt <= '0;
                end else if (gateFall) begin
                    state <= RELEASE;
                end else if (rateEvent) begin
                    if (state == ATTACK) begin
                        expCnt <= '0;
                        if (env == 8'hFF) begin
                            state <= DECAY_SUSTAIN;
                        end else begin
                            env <= env + 8'd1;
                            if (env == 8'hFE) state <= DECAY_SUSTAIN;
                        end
                    end else if (expDue) begin
                        expCnt <= '0;
                        if (decayAllowed) env <= env - 8'd1;
                    end else begin
                        expCnt <= expNext[EXP_W-1:0];
                    end
                end
            end
        end
    end

    assign oEnv = env;

endmodule
